// File: rtl/irq_controller_vec_if.sv
// Bus between the core's CSR/trap logic and the vectored interrupt controller.
// The master side is the core. It drives the request, enable and return
// strobes and receives the trap request, cause and acknowledge.
interface irq_controller_vec_if #(
  parameter int N_IRQ = 16
);
  logic             exception_i;
  logic [N_IRQ-1:0] irq_req_i;
  logic [N_IRQ-1:0] mie_i;
  logic             mret_i;
  logic             irq_o;
  logic [31:0]      irq_cause_o;
  logic [N_IRQ-1:0] irq_ret_o;
  logic [N_IRQ-1:0] irq_pending_o;
  logic             busy_o;

  modport master (
    output exception_i, irq_req_i, mie_i, mret_i,
    input  irq_o, irq_cause_o, irq_ret_o, irq_pending_o, busy_o
  );

  modport slave (
    input  exception_i, irq_req_i, mie_i, mret_i,
    output irq_o, irq_cause_o, irq_ret_o, irq_pending_o, busy_o
  );
endinterface

// File: rtl/irq_controller_vec.sv
// Vectored multi-channel interrupt controller.
// Level or rising-edge channels are masked by mie. The lowest eligible index
// wins. One interrupt or exception is tracked in service at a time, and the
// serviced channel is acknowledged one-hot on mret.
module irq_controller_vec #(
  parameter int          N_IRQ      = 16,
  parameter logic [31:0] EDGE_MASK  = 32'h0000_0000,
  parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  irq_controller_vec_if.slave  bus
);

  localparam int               IDW     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [N_IRQ-1:0] EDGE_CH = EDGE_MASK[N_IRQ-1:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ISR  = 2'd1,
    ST_EXC  = 2'd2
  } state_t;

  state_t           r_state;
  logic [N_IRQ-1:0] r_req_q;
  logic [N_IRQ-1:0] r_req_p;
  logic [N_IRQ-1:0] r_pend_edge;
  logic [IDW-1:0]   r_active_id;
  logic [31:0]      r_cause;

  logic [N_IRQ-1:0] w_pend;
  logic [N_IRQ-1:0] w_eligible;
  logic [N_IRQ-1:0] w_edge_set;
  logic [N_IRQ-1:0] w_take_vec;
  logic [N_IRQ-1:0] w_ret_vec;
  logic [IDW-1:0]   w_sel;
  logic [31:0]      w_cause;
  logic             w_any;
  logic             w_take;
  logic             w_in_isr_ret;

  // Register the raw request lines once, and keep the previous sample for edge detection.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_req_q <= '0;
      r_req_p <= '0;
    end else begin
      r_req_q <= bus.irq_req_i;
      r_req_p <= r_req_q;
    end
  end

  // Rising edges only matter on edge-configured channels.
  assign w_edge_set = r_req_q & ~r_req_p & EDGE_CH;

  // Per-channel pending source, take strobe and return acknowledge.
  for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_chan
    assign w_pend[gi]     = EDGE_CH[gi] ? r_pend_edge[gi] : r_req_q[gi];
    assign w_take_vec[gi] = w_take && (w_sel == IDW'(gi));
    assign w_ret_vec[gi]  = w_in_isr_ret && (r_active_id == IDW'(gi));
  end

  // Masking acts on the current mie value, so enabling a channel takes effect immediately.
  assign w_eligible = w_pend & bus.mie_i;
  assign w_any      = |w_eligible;

  // Lowest-index eligible channel has the highest priority.
  always_comb begin
    w_sel = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (w_eligible[k]) begin
        w_sel = IDW'(k);
      end
    end
  end

  assign w_cause = CAUSE_BASE + 32'(w_sel);

  // An exception in IDLE pre-empts any eligible interrupt. No nesting is allowed outside IDLE.
  assign w_take       = (r_state == ST_IDLE) && !bus.exception_i && w_any;
  assign w_in_isr_ret = (r_state == ST_ISR) && bus.mret_i;

  // Edge-pending latch: the channel is cleared when taken, but a new edge in the same cycle keeps it set.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pend_edge <= '0;
    end else begin
      r_pend_edge <= (w_edge_set | (r_pend_edge & ~w_take_vec)) & EDGE_CH;
    end
  end

  // Service FSM: capture the taken channel and its cause, and leave service on mret.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_active_id <= '0;
      r_cause     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.exception_i) begin
            r_state <= ST_EXC;
          end else if (w_any) begin
            r_state     <= ST_ISR;
            r_active_id <= w_sel;
            r_cause     <= w_cause;
          end
        end
        ST_ISR: begin
          if (bus.mret_i) begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXC: begin
          if (bus.mret_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The trap request and cause are live in the take cycle. At all other times the cause shows the latched value.
  assign bus.irq_o         = w_take;
  assign bus.irq_cause_o   = w_take ? w_cause : r_cause;
  assign bus.irq_ret_o     = w_ret_vec;
  assign bus.irq_pending_o = w_pend;
  assign bus.busy_o        = (r_state != ST_IDLE);

  // The acknowledge is at most one-hot.
  a_ret_onehot: assert property (@(posedge clk_i) disable iff (!rst_i)
    $onehot0(bus.irq_ret_o));

  // A trap request is only ever raised from IDLE.
  a_irq_idle: assert property (@(posedge clk_i) disable iff (!rst_i)
    bus.irq_o |-> (r_state == ST_IDLE));

endmodule

// File: tb/tb_irq_controller_vec.sv
// Scoreboard bench for irq_controller_vec.
// Channel 5 is edge-sensitive and all other channels are level-sensitive.
// Expected takes and acknowledges are queued as stimulus is driven. A negedge
// monitor pops and compares them whenever the DUT raises irq_o or irq_ret_o.
module tb_irq_controller_vec;

  localparam int          N    = 16;
  localparam logic [31:0] BASE = 32'h8000_0010;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  irq_controller_vec_if #(.N_IRQ(N)) bus_if ();

  irq_controller_vec #(
    .N_IRQ      (N),
    .EDGE_MASK  (32'h0000_0020),
    .CAUSE_BASE (BASE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_if)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] take_q[$];
  logic [15:0] ret_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor: every take and every acknowledge must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.irq_o) begin
        if (take_q.size() == 0) begin
          check("unexpected_take", 32'(bus_if.irq_o), 32'h0);
        end else begin
          logic [31:0] exp_cause;
          exp_cause = take_q.pop_front();
          $display("take  cause=%h expected=%h", bus_if.irq_cause_o, exp_cause);
          check("take_cause", bus_if.irq_cause_o, exp_cause);
        end
      end
      if (|bus_if.irq_ret_o) begin
        if (ret_q.size() == 0) begin
          check("unexpected_ret", 32'(bus_if.irq_ret_o), 32'h0);
        end else begin
          logic [15:0] exp_ret;
          exp_ret = ret_q.pop_front();
          $display("ret   ack=%h expected=%h", bus_if.irq_ret_o, exp_ret);
          check("ret_ack", 32'(bus_if.irq_ret_o), 32'(exp_ret));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus_if.exception_i = 1'b0;
    bus_if.irq_req_i   = '0;
    bus_if.mie_i       = '0;
    bus_if.mret_i      = 1'b0;

    // Reset state
    step(); step(); at_neg();
    check("rst_irq",     32'(bus_if.irq_o),         32'h0);
    check("rst_cause",   bus_if.irq_cause_o,        32'h0);
    check("rst_ret",     32'(bus_if.irq_ret_o),     32'h0);
    check("rst_pending", 32'(bus_if.irq_pending_o), 32'h0);
    check("rst_busy",    32'(bus_if.busy_o),        32'h0);
    step(); rst_n = 1'b1;
    step();

    // T1: level channel 3, one-cycle latency, then return
    step(); bus_if.mie_i = 16'h0008; bus_if.irq_req_i = 16'h0008; take_q.push_back(BASE + 32'd3);
    step(); bus_if.irq_req_i = '0; at_neg();
    check("t1_irq",      32'(bus_if.irq_o),  32'h1);
    check("t1_busy_pre", 32'(bus_if.busy_o), 32'h0);
    step(); at_neg();
    check("t1_busy",     32'(bus_if.busy_o), 32'h1);
    check("t1_cause",    bus_if.irq_cause_o, BASE + 32'd3);
    step(); bus_if.mret_i = 1'b1; ret_q.push_back(16'h0008); at_neg();
    check("t1_ret",      32'(bus_if.irq_ret_o), 32'h0008);
    step(); bus_if.mret_i = 1'b0; at_neg();
    check("t1_idle",     32'(bus_if.busy_o),    32'h0);
    check("t1_ret_once", 32'(bus_if.irq_ret_o), 32'h0);

    // T2: priority ch2 over ch9, then ch9 is taken after return
    step(); bus_if.mie_i = 16'h0204; bus_if.irq_req_i = 16'h0204; take_q.push_back(BASE + 32'd2);
    step(); bus_if.irq_req_i = 16'h0200; at_neg();
    check("t2_irq", 32'(bus_if.irq_o), 32'h1);
    step(); at_neg();
    check("t2_busy", 32'(bus_if.busy_o), 32'h1);
    step(); bus_if.mret_i = 1'b1; ret_q.push_back(16'h0004); take_q.push_back(BASE + 32'd9); at_neg();
    check("t2_no_nest", 32'(bus_if.irq_o), 32'h0);
    step(); bus_if.mret_i = 1'b0; bus_if.irq_req_i = '0; at_neg();
    check("t2_irq9", 32'(bus_if.irq_o), 32'h1);
    step(); at_neg();
    check("t2_busy9", 32'(bus_if.busy_o), 32'h1);
    step(); bus_if.mret_i = 1'b1; ret_q.push_back(16'h0200);
    step(); bus_if.mret_i = 1'b0; at_neg();
    check("t2_idle", 32'(bus_if.busy_o), 32'h0);

    // T3: edge channel 5 latched while masked, then enabled, then re-armed during ISR
    step(); bus_if.mie_i = '0; bus_if.irq_req_i = 16'h0020;
    step(); bus_if.irq_req_i = '0;
    step(); at_neg();
    check("t3_pend",   32'(bus_if.irq_pending_o), 32'h0020);
    check("t3_masked", 32'(bus_if.irq_o),         32'h0);
    step(); step(); at_neg();
    check("t3_latched", 32'(bus_if.irq_pending_o), 32'h0020);
    step(); bus_if.mie_i = 16'h0020; take_q.push_back(BASE + 32'd5); #1;
    check("t3_same_cycle", 32'(bus_if.irq_o), 32'h1);
    step(); at_neg();
    check("t3_cleared", 32'(bus_if.irq_pending_o), 32'h0);
    check("t3_busy",    32'(bus_if.busy_o),        32'h1);
    step(); bus_if.irq_req_i = 16'h0020;
    step(); bus_if.irq_req_i = '0;
    step(); at_neg();
    check("t3_pend2",    32'(bus_if.irq_pending_o), 32'h0020);
    check("t3_no_nest2", 32'(bus_if.irq_o),         32'h0);
    step(); bus_if.mret_i = 1'b1; ret_q.push_back(16'h0020); take_q.push_back(BASE + 32'd5);
    step(); bus_if.mret_i = 1'b0; at_neg();
    check("t3_retake", 32'(bus_if.irq_o), 32'h1);
    step(); bus_if.mret_i = 1'b1; ret_q.push_back(16'h0020);
    step(); bus_if.mret_i = 1'b0; at_neg();
    check("t3_pend_done", 32'(bus_if.irq_pending_o), 32'h0);

    // T4: exception beats an eligible channel 0
    step(); bus_if.mie_i = 16'h0001; bus_if.irq_req_i = 16'h0001;
    step(); bus_if.exception_i = 1'b1; at_neg();
    check("t4_exc_blocks", 32'(bus_if.irq_o), 32'h0);
    step(); bus_if.exception_i = 1'b0; at_neg();
    check("t4_busy",   32'(bus_if.busy_o), 32'h1);
    check("t4_no_irq", 32'(bus_if.irq_o),  32'h0);
    step(); bus_if.mret_i = 1'b1; take_q.push_back(BASE); at_neg();
    check("t4_no_ret", 32'(bus_if.irq_ret_o), 32'h0);
    step(); bus_if.mret_i = 1'b0; bus_if.irq_req_i = '0; at_neg();
    check("t4_take0",  32'(bus_if.irq_o), 32'h1);
    check("t4_cause0", bus_if.irq_cause_o, BASE);
    step(); bus_if.mret_i = 1'b1; ret_q.push_back(16'h0001);
    step(); bus_if.mret_i = 1'b0;

    // T5: mret in IDLE is ignored; asynchronous reset in the middle of an ISR
    step(); bus_if.mret_i = 1'b1; at_neg();
    check("t5_idle_mret", 32'(bus_if.irq_ret_o), 32'h0);
    check("t5_idle_busy", 32'(bus_if.busy_o),    32'h0);
    step(); bus_if.mret_i = 1'b0; bus_if.mie_i = 16'h0008; bus_if.irq_req_i = 16'h0008;
    take_q.push_back(BASE + 32'd3);
    step(); bus_if.irq_req_i = '0;
    step(); at_neg();
    check("t5_in_isr", 32'(bus_if.busy_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy",    32'(bus_if.busy_o),        32'h0);
    check("t5_rst_irq",     32'(bus_if.irq_o),         32'h0);
    check("t5_rst_cause",   bus_if.irq_cause_o,        32'h0);
    check("t5_rst_ret",     32'(bus_if.irq_ret_o),     32'h0);
    check("t5_rst_pending", 32'(bus_if.irq_pending_o), 32'h0);
    step(); rst_n = 1'b1;
    step(); at_neg();
    check("t5_post_idle", 32'(bus_if.busy_o), 32'h0);

    // T6: an edge set in the same cycle as the take keeps channel 5 pending
    step(); bus_if.mie_i = '0; bus_if.irq_req_i = 16'h0020;
    step(); bus_if.irq_req_i = '0;
    step();
    step(); bus_if.irq_req_i = 16'h0020;
    step(); bus_if.mie_i = 16'h0020; bus_if.irq_req_i = '0; take_q.push_back(BASE + 32'd5); at_neg();
    check("t6_irq", 32'(bus_if.irq_o), 32'h1);
    step(); at_neg();
    check("t6_set_wins", 32'(bus_if.irq_pending_o), 32'h0020);
    check("t6_busy",     32'(bus_if.busy_o),        32'h1);
    step(); bus_if.mret_i = 1'b1; ret_q.push_back(16'h0020); take_q.push_back(BASE + 32'd5);
    step(); bus_if.mret_i = 1'b0; at_neg();
    check("t6_retake", 32'(bus_if.irq_o), 32'h1);
    step(); at_neg();
    check("t6_pend_clr", 32'(bus_if.irq_pending_o), 32'h0);
    step(); bus_if.mret_i = 1'b1; ret_q.push_back(16'h0020);
    step(); bus_if.mret_i = 1'b0;
    step(); step(); at_neg();

    check("sb_take_empty", 32'(take_q.size()), 32'h0);
    check("sb_ret_empty",  32'(ret_q.size()),  32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
